// File: rtl/spi_slave_if.sv
// SPI slave serial front end: deserialises 1+10-bit MOSI frames into rx words and shifts read bytes out on MISO.
// Optional macro SPI_TX_TIMEOUT_EN bounds the wait for tx_valid after a read-data word.
module spi_slave_if #(
  parameter int unsigned DATA_WIDTH = 8
`ifdef SPI_TX_TIMEOUT_EN
  , parameter int unsigned TX_TIMEOUT = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid
);

  localparam int unsigned RX_W  = DATA_WIDTH + 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TXC_W = $clog2(DATA_WIDTH + 1);
`ifdef SPI_TX_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TX_TIMEOUT + 1);
`endif

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [RX_W-2:0]         rx_shift_q, rx_shift_d;
  logic [RX_W-1:0]         rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    miso_q, miso_d;
  logic                    rd_seen_q, rd_seen_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [TXC_W-1:0]        tx_cnt_q, tx_cnt_d;
  logic                    tx_busy_q, tx_busy_d;
  logic                    tx_done_q, tx_done_d;
`ifdef SPI_TX_TIMEOUT_EN
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      rd_seen_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      rd_seen_q  <= rd_seen_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
`ifdef SPI_TX_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Next-state and output logic; MISO and rx_valid default low every cycle
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    miso_d     = 1'b0;
    rd_seen_d  = rd_seen_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = tx_done_q;
`ifdef SPI_TX_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    if (SS_n) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      tx_busy_d = 1'b0;
      tx_done_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CHK_CMD;
          bit_cnt_d = '0;
          tx_busy_d = 1'b0;
          tx_done_d = 1'b0;
        end
        CHK_CMD: begin
          if (!MOSI)          state_d = WRITE;
          else if (rd_seen_q) state_d = READ_DATA;
          else                state_d = READ_ADD;
        end
        default: begin
          if (bit_cnt_q < CNT_W'(RX_W)) begin
            // Receive phase; counter stops at RX_W so extra bits are ignored
            rx_shift_d = {rx_shift_q[RX_W-3:0], MOSI};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(RX_W - 1)) begin
              rx_data_d  = {rx_shift_q, MOSI};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) rd_seen_d = 1'b1;
`ifdef SPI_TX_TIMEOUT_EN
              wait_cnt_d = '0;
`endif
            end
          end else if (state_q == READ_DATA && !tx_done_q) begin
            if (tx_busy_q) begin
              if (tx_cnt_q != '0) begin
                miso_d     = tx_shift_q[DATA_WIDTH-1];
                tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                tx_cnt_d   = tx_cnt_q - TXC_W'(1);
              end else begin
                tx_busy_d = 1'b0;
                tx_done_d = 1'b0 | 1'b1;
                rd_seen_d = 1'b0;
              end
            end else if (tx_valid) begin
              miso_d     = tx_data[DATA_WIDTH-1];
              tx_shift_d = {tx_data[DATA_WIDTH-2:0], 1'b0};
              tx_cnt_d   = TXC_W'(DATA_WIDTH - 1);
              tx_busy_d  = 1'b1;
            end
`ifdef SPI_TX_TIMEOUT_EN
            else if (wait_cnt_q == WAIT_W'(TX_TIMEOUT - 1)) begin
              tx_done_d = 1'b1;
              rd_seen_d = 1'b0;
            end else begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
`endif
          end
        end
      endcase
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
